// File: rtl/flash.sv
// LED flasher: a synchronized rising edge on sw launches a burst of
// FLASH_COUNT on-phases separated by off-phases, then returns to idle.
module flash #(
    parameter int unsigned ON_CYCLES   = 2,
    parameter int unsigned OFF_CYCLES  = 2,
    parameter int unsigned FLASH_COUNT = 3
) (
    input  logic sw,
    output logic ld,
    input  logic clk,
    input  logic rst
);

    localparam int unsigned PMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned PW   = $clog2(PMAX + 1);
    localparam int unsigned FW   = $clog2(FLASH_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   phase;
    logic [FW-1:0]   flashes;
    logic            s1;
    logic            s2;
    logic            s2_d;
    logic            start;

    assign start = s2 & ~s2_d;

    // Two-flop synchronizer plus edge-detect delay flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= sw;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // Burst sequencer; ld is loaded with the value of (next state == ON).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ld      <= 1'b0;
            phase   <= '0;
            flashes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (start) begin
                        state   <= ON;
                        ld      <= 1'b1;
                        flashes <= FW'(1);
                    end else begin
                        ld      <= 1'b0;
                        flashes <= '0;
                    end
                end
                ON: begin
                    if (phase == PW'(ON_CYCLES - 1)) begin
                        phase <= '0;
                        ld    <= 1'b0;
                        if (flashes == FW'(FLASH_COUNT)) begin
                            state   <= IDLE;
                            flashes <= '0;
                        end else begin
                            state <= OFF;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                        ld    <= 1'b1;
                    end
                end
                OFF: begin
                    if (phase == PW'(OFF_CYCLES - 1)) begin
                        state   <= ON;
                        ld      <= 1'b1;
                        phase   <= '0;
                        flashes <= flashes + FW'(1);
                    end else begin
                        phase <= phase + PW'(1);
                        ld    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ld      <= 1'b0;
                    phase   <= '0;
                    flashes <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash.sv
// Directed bench for flash: default timing plus two parameter variants.
module tb_flash;

    logic clk;
    logic rst;
    logic sw_a, sw_b, sw_c;
    logic ld_a, ld_b, ld_c;

    int checks   = 0;
    int failures = 0;

    flash dut_a (.sw(sw_a), .ld(ld_a), .clk(clk), .rst(rst));
    flash #(.ON_CYCLES(1), .OFF_CYCLES(3), .FLASH_COUNT(1))
        dut_b (.sw(sw_b), .ld(ld_b), .clk(clk), .rst(rst));
    flash #(.ON_CYCLES(1), .OFF_CYCLES(3), .FLASH_COUNT(4))
        dut_c (.sw(sw_c), .ld(ld_c), .clk(clk), .rst(rst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ld_of(input int w);
        case (w)
            0:       return ld_a;
            1:       return ld_b;
            default: return ld_c;
        endcase
    endfunction

    task automatic set_sw(input int w, input logic v);
        case (w)
            0:       sw_a = v;
            1:       sw_b = v;
            default: sw_c = v;
        endcase
    endtask

    task automatic expect_low(input int w, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, ld_of(w), 1'b0);
        end
    endtask

    // Raise sw, check the 2-edge latency, then the first len pattern cycles
    // (pat bit i = ld after the i-th edge of the burst).
    task automatic run_burst(input int w, input logic [15:0] pat, input int len,
                             input bit toggle, input string tag);
        set_sw(w, 1'b1);
        expect_low(w, 2, {tag, "_latency"});
        for (int i = 0; i < len; i++) begin
            tick();
            check(tag, ld_of(w), pat[i]);
            if (toggle) begin
                if (i == 1 || i == 4) set_sw(w, 1'b0);
                if (i == 3 || i == 5) set_sw(w, 1'b1);
            end
        end
    endtask

    logic [15:0] pat_def;
    logic [15:0] pat_b;
    logic [15:0] pat_c;

    initial begin
        pat_def = 16'b0000_0011_0011_0011;
        pat_b   = 16'b0000_0000_0000_0001;
        pat_c   = 16'b0001_0001_0001_0001;
        rst  = 1'b1;
        sw_a = 1'b0;
        sw_b = 1'b0;
        sw_c = 1'b0;

        tick();
        tick();
        check("reset_ld_a", ld_a, 1'b0);
        check("reset_ld_b", ld_b, 1'b0);
        check("reset_ld_c", ld_c, 1'b0);
        rst = 1'b0;
        expect_low(0, 20, "idle_sw_low");

        // Single burst, sw held high well past the end: no retrigger.
        run_burst(0, pat_def, 10, 1'b0, "burst1");
        expect_low(0, 6, "burst1_tail_sw_high");

        // Second burst with sw pulsing mid-burst: pattern must be unchanged.
        sw_a = 1'b0;
        expect_low(0, 3, "gap1");
        run_burst(0, pat_def, 10, 1'b1, "burst2_toggle");
        expect_low(0, 8, "burst2_tail");

        // Reset during the second ON phase, no resumption afterwards.
        sw_a = 1'b0;
        expect_low(0, 3, "gap2");
        run_burst(0, pat_def, 5, 1'b0, "burst3_pre_reset");
        rst  = 1'b1;
        sw_a = 1'b0;
        tick();
        check("midburst_reset_ld", ld_a, 1'b0);
        rst = 1'b0;
        expect_low(0, 15, "after_reset");

        // sw already high while reset deasserts produces a fresh edge.
        rst  = 1'b1;
        sw_a = 1'b1;
        expect_low(0, 2, "reset_sw_high");
        rst = 1'b0;
        run_burst(0, pat_def, 10, 1'b0, "burst_after_reset");
        expect_low(0, 4, "burst_after_reset_tail");
        sw_a = 1'b0;

        // Parameter variants.
        run_burst(1, pat_b, 1, 1'b0, "single_pulse");
        expect_low(1, 6, "single_pulse_tail");
        run_burst(2, pat_c, 13, 1'b0, "four_flash");
        expect_low(2, 6, "four_flash_tail");
        check("b_idle_during_c", ld_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
